// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, LSB first, valid/ready load handshake.
// Defining PISO_PARITY_EN appends an even-parity bit after the MSB.
module piso_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             data_out,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_done
);
`ifdef PISO_PARITY_EN
    localparam int FL = WIDTH + 1;
    logic [FL-1:0] word;
    assign word = {^data_in, data_in};
`else
    localparam int FL = WIDTH;
    logic [FL-1:0] word;
    assign word = data_in;
`endif
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t        state;
    logic [FL-1:0] sreg;
    logic [CW-1:0] cnt;
    logic          last, accept;
    assign last       = state == SHIFT && cnt == CW'(FL - 1);
    assign load_ready = state == IDLE || last;
    assign accept     = load_valid && load_ready;
    // sreg[0] is the bit on the line; it drains to zero by the end of each frame
    assign data_out   = sreg[0];
    assign out_valid  = state == SHIFT;
    assign busy       = state == SHIFT;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else if (accept) begin
            state      <= SHIFT;
            sreg       <= word;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else if (state == SHIFT) begin
            state      <= last ? IDLE : SHIFT;
            sreg       <= {1'b0, sreg[FL-1:1]};
            cnt        <= last ? '0 : cnt + CW'(1);
            frame_done <= !last && cnt == CW'(FL - 2);
        end
    end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: checks piso_tx against a queue-of-pending-bits model plus a loopback SIPO.
// Directed cases from the feature list followed by randomized traffic and resets.
module tb_piso_tx;
    localparam int W = 4;
    logic         clk = 1'b0;
    logic         reset, load_valid, load_ready, data_out, out_valid, busy, frame_done;
    logic [W-1:0] data_in;
    int           checks = 0;
    int           failures = 0;
    bit           q[$];
    logic [W-1:0] wq[$];
    logic [W-1:0] sipo = '0;

    piso_tx #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .data_in(data_in), .data_out(data_out), .out_valid(out_valid), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare outputs after it.
    task automatic step(input logic r, input logic v, input logic [W-1:0] d);
        logic line;
        bit   acc;
        reset = r; load_valid = v; data_in = d;
        #1 line = data_out;
        acc = !r && v && q.size() <= 1;
        @(posedge clk);
        sipo = {line, sipo[W-1:1]};
        if (r) begin
            q.delete();
            wq.delete();
        end else if (q.size() > 0) begin
`ifndef PISO_PARITY_EN
            if (q.size() == 1 && wq.size() > 0) check("sipo_q", sipo, wq[0]);
`endif
            if (q.size() == 1 && wq.size() > 0) void'(wq.pop_front());
            void'(q.pop_front());
        end
        if (acc) begin
            for (int i = 0; i < W; i++) q.push_back(d[i]);
`ifdef PISO_PARITY_EN
            q.push_back(^d);
`endif
            wq.push_back(d);
        end
        #1;
        check("out_valid", out_valid, q.size() > 0);
        check("busy", busy, q.size() > 0);
        check("data_out", data_out, q.size() > 0 ? q[0] : 1'b0);
        check("frame_done", frame_done, q.size() == 1);
        check("load_ready", load_ready, q.size() <= 1);
    endtask

    initial begin
        step(1, 0, '0);
        step(1, 1, 4'hF);
        // single frame 1011
        step(0, 1, 4'b1011);
        for (int i = 0; i < 7; i++) step(0, 0, 4'($urandom));
        // loopback word
        step(0, 1, 4'b0110);
        for (int i = 0; i < 6; i++) step(0, 0, 4'($urandom));
        // back-to-back A then 5 with load_valid held
        step(0, 1, 4'hA);
        for (int i = 0; i < W - 1; i++) step(0, 1, 4'hA);
        step(0, 1, 4'h5);
        for (int i = 0; i < 7; i++) step(0, 0, 4'h0);
        // load requested during busy
        step(0, 1, 4'h3);
        for (int i = 0; i < 6; i++) step(0, 1, 4'hF);
        for (int i = 0; i < 6; i++) step(0, 0, 4'h0);
        // reset mid-frame then a clean frame
        step(0, 1, 4'hC);
        step(0, 0, 4'h0);
        step(1, 0, 4'h0);
        step(0, 0, 4'h0);
        step(0, 1, 4'h9);
        for (int i = 0; i < 7; i++) step(0, 0, 4'h0);
        // parity-zero word (checked as data only in the default build)
        step(0, 1, 4'b0011);
        for (int i = 0; i < 7; i++) step(0, 0, 4'h0);
        // randomized traffic with sparse resets and mid-frame data_in churn
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, 4'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
